// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front-end for the pipelined datapath. It owns the fetch
//   PC and issues in-order requests to a variable-latency instruction memory.
//   Returned words are buffered with their PCs in a circular queue. The oldest
//   entry is presented to the IF/ID register. After a taken branch or jump
//   from Execute, responses still in flight for the old stream are dropped.
//
//   Optional feature macro: FETCH_QUEUE_BYPASS_EN
//     When defined, a response for an empty head is forwarded combinationally
//     to instF/PCF/validF in the same cycle (0-cycle response latency).
//     When undefined, outputs depend only on queue state (1-cycle latency).
//
//   Ports
//     clk, reset            rising-edge clock, async active-low reset
//     imem_req_valid/ready  request handshake; imem_req_addr is word aligned
//     imem_rsp_valid/data   in-order responses, always accepted
//     redirect_valid/pc     taken branch/jump from Execute
//     stallF                consumer stall; the head is held while high
//     instF, PCF, PCPlus4F  head instruction, its PC and PC+4
//     validF                head entry holds a deliverable instruction
//     fetch_stall           ~validF, to the hazard unit
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stallF,
  output logic [31:0] instF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF,
  output logic        fetch_stall
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [31:0]   NOP_C   = 32'h0000_0013;

  // Pointer advance; DEPTH is a power of two so the wrap is free.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1'b1);
  endfunction

  logic [31:0]    pc_mem_r   [DEPTH];
  logic [31:0]    inst_mem_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
  logic [PW-1:0]  head_r, fill_r, tail_r;
  // pend_r counts current-stream requests still awaiting their response.
  logic [CW-1:0]  alloc_r, discard_r, pend_r;
  logic [31:0]    fetch_pc_r;
  // run_r keeps the request port quiet while reset is applied.
  logic           run_r;

  logic [CW:0]    occ_s;
  logic [CW-1:0]  in_flight_s, redir_discard_s;
  logic           req_valid_s, issue_s, drop_s, keep_s;
  logic           head_filled_s, bypass_s, valid_s, pop_s;
  logic [31:0]    head_inst_s, head_pc_s;

  // Per-cycle decisions: issue, response routing, bypass and pop.
  always_comb begin
    occ_s         = {1'b0, alloc_r} + {1'b0, discard_r};
    req_valid_s   = run_r & ~redirect_valid & (occ_s < DEPTH_W);
    issue_s       = req_valid_s & imem_req_ready;
    drop_s        = imem_rsp_valid & (discard_r != ZERO_C);
    // A response arriving with a redirect belongs to the old stream.
    keep_s        = imem_rsp_valid & (discard_r == ZERO_C) & ~redirect_valid;
    head_filled_s = filled_r[head_r];
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s      = ~head_filled_s & keep_s & (fill_r == head_r) & (pend_r != ZERO_C);
`else
    bypass_s      = 1'b0;
`endif
    valid_s       = head_filled_s | bypass_s;
    pop_s         = valid_s & ~stallF & ~redirect_valid;
    // On redirect every outstanding request becomes stale, less the one
    // whose response is being absorbed this very cycle.
    in_flight_s   = discard_r + pend_r;
    if (imem_rsp_valid && (in_flight_s != ZERO_C)) begin
      redir_discard_s = in_flight_s - ONE_C;
    end else begin
      redir_discard_s = in_flight_s;
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign head_inst_s = head_filled_s ? inst_mem_r[head_r] : imem_rsp_data;
`else
  assign head_inst_s = inst_mem_r[head_r];
`endif
  assign head_pc_s      = pc_mem_r[head_r];
  assign instF          = valid_s ? head_inst_s : NOP_C;
  assign PCF            = valid_s ? head_pc_s : 32'h0000_0000;
  assign PCPlus4F       = PCF + 32'd4;
  assign validF         = valid_s;
  assign fetch_stall    = ~valid_s;
  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;

  // Queue payload storage; its contents only matter where filled_r says so.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      pc_mem_r[tail_r] <= fetch_pc_r;
    end
    if (keep_s) begin
      inst_mem_r[fill_r] <= imem_rsp_data;
    end
  end

  // Control state: pointers, counters, filled flags and the fetch PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r      <= 1'b0;
      fetch_pc_r <= RESET_PC;
      head_r     <= {PW{1'b0}};
      fill_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      filled_r   <= {DEPTH{1'b0}};
      alloc_r    <= ZERO_C;
      discard_r  <= ZERO_C;
      pend_r     <= ZERO_C;
    end else begin
      run_r <= 1'b1;
      if (redirect_valid) begin
        head_r     <= tail_r;
        fill_r     <= tail_r;
        filled_r   <= {DEPTH{1'b0}};
        alloc_r    <= ZERO_C;
        pend_r     <= ZERO_C;
        discard_r  <= redir_discard_s;
        fetch_pc_r <= redirect_pc & ~32'h0000_0003;
      end else begin
        if (issue_s) begin
          tail_r           <= ptr_inc(tail_r);
          fetch_pc_r       <= fetch_pc_r + 32'd4;
          filled_r[tail_r] <= 1'b0;
        end
        if (keep_s) begin
          fill_r           <= ptr_inc(fill_r);
          // A bypassed word that pops immediately never occupies the queue.
          filled_r[fill_r] <= ~(bypass_s & pop_s);
        end
        if (pop_s) begin
          head_r           <= ptr_inc(head_r);
          filled_r[head_r] <= 1'b0;
        end
        alloc_r   <= alloc_r + CW'(issue_s) - CW'(pop_s);
        pend_r    <= pend_r + CW'(issue_s) - CW'(keep_s);
        discard_r <= discard_r - CW'(drop_s);
      end
    end
  end

endmodule
